// File: rtl/aes_pkg.sv
// Shared AES-128 types, FSM encodings, round constants and the S-box lookup
// used by the round engine, its key expansion and its round primitives.
package aes_pkg;

   localparam int NUM_ROUNDS = 10;

   typedef logic [127:0] state_t;
   typedef logic [127:0] key_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      FSM_IDLE = ST_IDLE,
      FSM_RUN  = ST_RUN,
      FSM_DONE = ST_DONE
   } fsm_state_t;

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] a);
      return SBOX[a];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Rounds outside 1..10 only occur on slices whose result is discarded.
   function automatic logic [7:0] rcon_of(input logic [3:0] r);
      logic [7:0] v;
      v = 8'h00;
      for (int i = 1; i <= NUM_ROUNDS; i++) begin
         if (r == 4'(i)) v = RCON[i];
      end
      return v;
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of on-the-fly AES-128 key expansion: previous round key plus
// rcon in, next round key out (RotWord, SubWord, XOR chain).
module aes_key_step
   import aes_pkg::*;
(
   input  logic [127:0] key_prev,
   input  logic [7:0]   rcon,
   output logic [127:0] key_next
);
   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot, sub;
   logic [31:0] n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = key_prev;
   assign rot = {w3[23:0], w3[31:24]};
   assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

   assign n0 = w0 ^ sub ^ {rcon, 24'h0};
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign key_next = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_round_prims.sv
// Combinational AES round primitives: SubBytes, ShiftRows, MixColumns and
// AddRoundKey. Byte 0 of a state sits in bits [127:120], column-major.
module aes_subbytes
   import aes_pkg::*;
(
   input  logic [127:0] din,
   output logic [127:0] dout
);
   for (genvar b = 0; b < 16; b++) begin : g_byte
      assign dout[8*b +: 8] = sbox(din[8*b +: 8]);
   end
endmodule

module aes_shiftrows (
   input  logic [127:0] din,
   output logic [127:0] dout
);
   // Row r of column c takes the byte from column (c + r) mod 4.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         localparam int DST = r + 4*c;
         localparam int SRC = r + 4*((c + r) % 4);
         assign dout[127-8*DST -: 8] = din[127-8*SRC -: 8];
      end
   end
endmodule

module aes_mixcolumns
   import aes_pkg::*;
(
   input  logic [127:0] din,
   output logic [127:0] dout
);
   for (genvar c = 0; c < 4; c++) begin : g_col
      localparam int TOP = 127 - 32*c;
      logic [7:0] a0, a1, a2, a3;
      assign a0 = din[TOP -: 8];
      assign a1 = din[TOP-8 -: 8];
      assign a2 = din[TOP-16 -: 8];
      assign a3 = din[TOP-24 -: 8];
      assign dout[TOP -: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign dout[TOP-8 -: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign dout[TOP-16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign dout[TOP-24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
   end
endmodule

module aes_addroundkey (
   input  logic [127:0] din,
   input  logic [127:0] rk,
   output logic [127:0] dout
);
   assign dout = din ^ rk;
endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryptor applying ROUNDS_PER_CYCLE rounds per clock.
// Optional completed-block counter enabled by defining AES_BLK_COUNT_EN.
//
// state | meaning
// IDLE  | in_ready high, waiting for a plaintext/key pair
// RUN   | rounds in flight, round_q is the first round applied this cycle
// DONE  | ciphertext held on out_data with out_valid until out_ready
module aes_round_engine
   import aes_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic [31:0]  blk_count
);
   localparam int RPC = ROUNDS_PER_CYCLE;

   if (!(RPC == 1 || RPC == 2 || RPC == 5 || RPC == 10)) begin : g_bad_rpc
      $error("aes_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
   end

   fsm_state_t fsm_q;
   state_t     blk_q;
   key_t       key_q;
   state_t     out_data_q;
   logic [3:0] round_q;
   logic [3:0] round_nxt;

   state_t st_chain  [0:RPC];
   key_t   key_chain [0:RPC];

   assign st_chain[0]  = blk_q;
   assign key_chain[0] = key_q;

   // Each slice derives its round key from the previous slice's key.
   for (genvar i = 0; i < RPC; i++) begin : g_round
      logic [3:0] slice_round;
      logic [7:0] rcon;
      state_t     sb, sr, mc, pre_ark;

      assign slice_round = round_q + 4'(i);
      assign rcon        = rcon_of(slice_round);

      aes_key_step u_key_step (
         .key_prev (key_chain[i]),
         .rcon     (rcon),
         .key_next (key_chain[i+1])
      );

      aes_subbytes   u_subbytes   (.din(st_chain[i]), .dout(sb));
      aes_shiftrows  u_shiftrows  (.din(sb),          .dout(sr));
      aes_mixcolumns u_mixcolumns (.din(sr),          .dout(mc));

      // The final round skips MixColumns.
      assign pre_ark = (slice_round == 4'(NUM_ROUNDS)) ? sr : mc;

      aes_addroundkey u_addroundkey (
         .din  (pre_ark),
         .rk   (key_chain[i+1]),
         .dout (st_chain[i+1])
      );
   end

   assign round_nxt = round_q + 4'(RPC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q      <= FSM_IDLE;
         blk_q      <= '0;
         key_q      <= '0;
         round_q    <= 4'd1;
         out_data_q <= '0;
      end else begin
         case (fsm_q)
            FSM_IDLE: begin
               if (in_valid) begin
                  blk_q   <= in_data ^ in_key;
                  key_q   <= in_key;
                  round_q <= 4'd1;
                  fsm_q   <= FSM_RUN;
               end
            end
            FSM_RUN: begin
               blk_q   <= st_chain[RPC];
               key_q   <= key_chain[RPC];
               round_q <= round_nxt;
               if (round_nxt > 4'(NUM_ROUNDS)) begin
                  out_data_q <= st_chain[RPC];
                  fsm_q      <= FSM_DONE;
               end
            end
            FSM_DONE: begin
               if (out_ready) fsm_q <= FSM_IDLE;
            end
            default: fsm_q <= FSM_IDLE;
         endcase
      end
   end

   assign in_ready  = (fsm_q == FSM_IDLE);
   assign out_valid = (fsm_q == FSM_DONE);
   assign out_data  = out_data_q;

`ifdef AES_BLK_COUNT_EN
   logic [31:0] blk_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_count_q <= '0;
      end else if (out_valid && out_ready) begin
         blk_count_q <= blk_count_q + 32'd1;
      end
   end

   assign blk_count = blk_count_q;
`else
   assign blk_count = 32'h0;
`endif

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: four instances (1, 2, 5 and 10 rounds per
// cycle) checked every cycle against a byte-level AES-128 reference model.
module tb_aes_round_engine;

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] PT_E  = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] CT_E  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

   logic clk;
   logic rst_n;
   logic         in_valid  [4];
   logic         in_ready  [4];
   logic [127:0] in_data   [4];
   logic [127:0] in_key    [4];
   logic         out_valid [4];
   logic         out_ready [4];
   logic [127:0] out_data  [4];
   logic [31:0]  blk_count [4];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      aes_round_engine #(
         .ROUNDS_PER_CYCLE((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_data   (in_data[g]),
         .in_key    (in_key[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_data  (out_data[g]),
         .blk_count (blk_count[g])
      );
   end

   function automatic int rpc_of(input int j);
      case (j)
         0: return 1;
         1: return 2;
         2: return 5;
         default: return 10;
      endcase
   endfunction

   // ---------------- reference model ----------------
   logic [7:0] sbox_t [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map.
   function automatic logic [7:0] sbox_calc(input logic [7:0] a);
      logic [7:0] p, r;
      p = a; r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      if (a == 8'h00) r = 8'h00;
      return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0]   s [16];
      logic [7:0]   k [16];
      logic [7:0]   t [16];
      logic [7:0]   tw [4];
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [127:0] vp, vk, res;
      vp = pt; vk = key;
      for (int i = 0; i < 16; i++) begin
         k[i] = vk[127:120];
         s[i] = vp[127:120] ^ vk[127:120];
         vp = vp << 8; vk = vk << 8;
      end
      rc = 8'h01;
      for (int rnd = 1; rnd <= 10; rnd++) begin
         tw[0] = sbox_t[k[13]] ^ rc;
         tw[1] = sbox_t[k[14]];
         tw[2] = sbox_t[k[15]];
         tw[3] = sbox_t[k[12]];
         for (int i = 0; i < 16; i++) k[i] = k[i] ^ ((i < 4) ? tw[i] : k[i-4]);
         rc = gmul(rc, 8'h02);
         for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
         if (rnd != 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
      end
      res = '0;
      for (int i = 0; i < 16; i++) res = {res[119:0], s[i]};
      return res;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Transaction-level view per instance: 0 idle, 1 computing, 2 holding result.
   int           mdl_phase [4];
   int           mdl_left  [4];
   logic [127:0] mdl_exp   [4];
   logic [31:0]  mdl_cnt   [4];

   always @(negedge clk) begin
      for (int j = 0; j < 4; j++) begin
         if (!rst_n) begin
            mdl_phase[j] = 0;
            mdl_cnt[j]   = '0;
            chk($sformatf("rst_in_ready[%0d]", j), 128'(in_ready[j]), 128'd1);
            chk($sformatf("rst_out_valid[%0d]", j), 128'(out_valid[j]), 128'd0);
            chk($sformatf("rst_out_data[%0d]", j), out_data[j], 128'd0);
            chk($sformatf("rst_blk_count[%0d]", j), 128'(blk_count[j]), 128'd0);
         end else begin
            chk($sformatf("in_ready[%0d]", j), 128'(in_ready[j]), 128'(mdl_phase[j] == 0));
            chk($sformatf("out_valid[%0d]", j), 128'(out_valid[j]), 128'(mdl_phase[j] == 2));
`ifdef AES_BLK_COUNT_EN
            chk($sformatf("blk_count[%0d]", j), 128'(blk_count[j]), 128'(mdl_cnt[j]));
`else
            chk($sformatf("blk_count[%0d]", j), 128'(blk_count[j]), 128'd0);
`endif
            if (mdl_phase[j] == 2)
               chk($sformatf("out_data[%0d]", j), out_data[j], mdl_exp[j]);
            case (mdl_phase[j])
               0: if (in_valid[j]) begin
                  mdl_exp[j]   = aes_enc(in_data[j], in_key[j]);
                  mdl_left[j]  = 10 / rpc_of(j);
                  mdl_phase[j] = 1;
               end
               1: begin
                  mdl_left[j] = mdl_left[j] - 1;
                  if (mdl_left[j] == 0) mdl_phase[j] = 2;
               end
               default: if (out_ready[j]) begin
                  mdl_phase[j] = 0;
                  mdl_cnt[j]   = mdl_cnt[j] + 32'd1;
               end
            endcase
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic accept(input int j, input logic [127:0] pt, input logic [127:0] key);
      logic acc;
      acc = 1'b0;
      in_data[j] = pt; in_key[j] = key; in_valid[j] = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         acc = in_ready[j];
         @(posedge clk); #1;
         if (acc) break;
      end
      in_valid[j] = 1'b0;
      chk($sformatf("accept_timeout[%0d]", j), 128'(acc), 128'd1);
   endtask

   // Latency counts clock edges from the accepting edge through the edge
   // after which out_valid is high.
   task automatic wait_valid(input int j, output int lat);
      lat = 1;
      for (int c = 0; c < 50; c++) begin
         if (out_valid[j]) break;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic drain(input int j);
      out_ready[j] = 1'b1;
      @(posedge clk); #1;
      out_ready[j] = 1'b0;
   endtask

   logic [127:0] blk_pt [4];
   logic [127:0] blk_ky [4];

   initial begin
      int lat, nacc, nout;
      int tout [4];
      logic acc_now;
      logic [127:0] snap;

      rst_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         in_valid[j] = 1'b0; out_ready[j] = 1'b0;
         in_data[j] = '0; in_key[j] = '0;
         mdl_phase[j] = 0; mdl_left[j] = 0; mdl_exp[j] = '0; mdl_cnt[j] = '0;
      end
      for (int v = 0; v < 256; v++) sbox_t[v] = sbox_calc(8'(v));
      #2 rst_n = 1'b0;

      chk("model_sbox_53", 128'(sbox_t[8'h53]), 128'hed);
      chk("model_fips_b", aes_enc(PT_B, KEY_B), CT_B);
      chk("model_fips_c1", aes_enc(PT_C, KEY_C), CT_C);
      chk("model_zero", aes_enc('0, '0), CT_Z);
      chk("model_ecb1", aes_enc(PT_E, KEY_B), CT_E);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", 128'(in_ready[0]), 128'd1);
      chk("reset_out_valid", 128'(out_valid[0]), 128'd0);
      chk("reset_out_data", out_data[0], 128'd0);
      chk("reset_blk_count", 128'(blk_count[0]), 128'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // FIPS-197 appendix B at one round per cycle, then backpressure.
      accept(0, PT_B, KEY_B);
      wait_valid(0, lat);
      chk("latency_rpc1", 128'(lat), 128'd11);
      chk("fips_b_data", out_data[0], CT_B);
      snap = out_data[0];
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         chk("bp_out_data_stable", out_data[0], snap);
         chk("bp_in_ready_low", 128'(in_ready[0]), 128'd0);
      end
      drain(0);
      chk("bp_in_ready_after", 128'(in_ready[0]), 128'd1);
`ifdef AES_BLK_COUNT_EN
      chk("bp_blk_count", 128'(blk_count[0]), 128'd1);
`else
      chk("bp_blk_count", 128'(blk_count[0]), 128'd0);
`endif

      // FIPS-197 appendix C.1 on the unrolled instances.
      for (int j = 1; j < 4; j++) begin
         accept(j, PT_C, KEY_C);
         wait_valid(j, lat);
         chk($sformatf("latency_rpc%0d", rpc_of(j)), 128'(lat), 128'(10 / rpc_of(j) + 1));
         chk($sformatf("fips_c1_rpc%0d", rpc_of(j)), out_data[j], CT_C);
         drain(j);
      end

      // Back-to-back: the next block is presented while the current one runs.
      blk_pt[0] = PT_B; blk_ky[0] = KEY_B;
      blk_pt[1] = PT_C; blk_ky[1] = KEY_C;
      blk_pt[2] = '0;   blk_ky[2] = '0;
      blk_pt[3] = PT_E; blk_ky[3] = KEY_B;
      nacc = 0; nout = 0;
      in_data[0] = blk_pt[0]; in_key[0] = blk_ky[0];
      in_valid[0] = 1'b1; out_ready[0] = 1'b1;
      for (int c = 0; c < 120 && nout < 4; c++) begin
         @(negedge clk);
         acc_now = in_valid[0] && in_ready[0];
         if (out_valid[0]) begin
            tout[nout] = cyc;
            nout++;
         end
         @(posedge clk); #1;
         if (acc_now) begin
            nacc++;
            if (nacc < 4) begin
               in_data[0] = blk_pt[nacc]; in_key[0] = blk_ky[nacc];
            end else begin
               in_valid[0] = 1'b0;
            end
         end
      end
      out_ready[0] = 1'b0;
      chk("b2b_blocks_out", 128'(nout), 128'd4);
      if (nout == 4) begin
         for (int k = 1; k < 4; k++)
            chk($sformatf("b2b_period_%0d", k), 128'(tout[k] - tout[k-1]), 128'd12);
      end

      // Asynchronous reset while round 5 is being applied.
      accept(0, PT_B, KEY_B);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrun_rst_in_ready", 128'(in_ready[0]), 128'd1);
      chk("midrun_rst_out_valid", 128'(out_valid[0]), 128'd0);
      chk("midrun_rst_out_data", out_data[0], 128'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      accept(0, PT_C, KEY_C);
      wait_valid(0, lat);
      chk("post_rst_latency", 128'(lat), 128'd11);
      chk("post_rst_data", out_data[0], CT_C);
      drain(0);

`ifdef AES_BLK_COUNT_EN
      force g_dut[0].u_dut.blk_count_q = 32'hffff_ffff;
      mdl_cnt[0] = 32'hffff_ffff;
      @(posedge clk); #1;
      release g_dut[0].u_dut.blk_count_q;
      chk("wrap_preload", 128'(blk_count[0]), 128'hffff_ffff);
      accept(0, PT_E, KEY_B);
      wait_valid(0, lat);
      chk("wrap_data", out_data[0], CT_E);
      drain(0);
      chk("wrap_blk_count", 128'(blk_count[0]), 128'd0);
`endif

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
      $fatal(1, "watchdog");
   end

endmodule
